// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank: SPI mode-0 responder with a local register bank.
// sclk/cs/mosi are oversampled in the clk domain through synchronizers.
// Write frames commit into the bank. A read command is followed by a separate
// cs-low window during which the addressed register is shifted out on miso.
// Optional feature: define SPI_SLV_RD_TIMEOUT_EN to drop a pending read that
// waits longer than RD_TIMEOUT clk cycles for its data window.
module spi_slave_regbank #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  wr_vld,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_vld,
    output logic                  frame_err,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata
);

    localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CMD_LEN   = 1 + ADDR_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WR_DONE, S_RD_CMD, S_RD_WAIT, S_RD_SHIFT, S_RD_END
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic mosi_smp_q, mosi_smp_d;
    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d, shin;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]  rd_sh_q, rd_sh_d;
    logic [DATA_WIDTH-1:0]  bank_q [DEPTH];
    logic [DATA_WIDTH-1:0]  bank_d [DEPTH];
    logic                   wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d;
    logic                   frame_err_q, frame_err_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   spi_we;
`ifdef SPI_SLV_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
`endif

    // Synchronizers plus registered edge strobes; mosi is delayed to align with them
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
        mosi_smp_d  = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
        cs_rise_d   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
        cs_fall_d   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    end

    // Frame FSM, shift registers and bank update; cs events outrank sclk events
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rd_addr_d   = rd_addr_q;
        rd_sh_d     = rd_sh_q;
        bank_d      = bank_q;
        wr_vld_d    = 1'b0;
        rd_vld_d    = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        spi_we      = 1'b0;
        cnt_inc     = cnt_q + CNT_W'(1);
        shin        = {shreg_q[FRAME_LEN-2:0], mosi_smp_q};
`ifdef SPI_SLV_RD_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cs_fall_q) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            S_CMD: begin
                if (cs_rise_q) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (sclk_rise_q) begin
                    shreg_d = shin;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_W'(CMD_LEN) && !shin[ADDR_WIDTH]) begin
                        rd_addr_d = shin[ADDR_WIDTH-1:0];
                        state_d   = S_RD_CMD;
                    end else if (cnt_inc == CNT_W'(FRAME_LEN)) begin
                        spi_we    = 1'b1;
                        wr_vld_d  = 1'b1;
                        wr_addr_d = shin[FRAME_LEN-2:DATA_WIDTH];
                        wr_data_d = shin[DATA_WIDTH-1:0];
                        state_d   = S_WR_DONE;
                    end
                end
            end
            S_WR_DONE: begin
                if (cs_rise_q) state_d = S_IDLE;
            end
            S_RD_CMD: begin
                if (cs_rise_q) begin
                    state_d = S_RD_WAIT;
`ifdef SPI_SLV_RD_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (sclk_rise_q) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (cs_fall_q) begin
                    rd_sh_d = bank_q[rd_addr_q];
                    cnt_d   = '0;
                    state_d = S_RD_SHIFT;
                end
`ifdef SPI_SLV_RD_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_RD_SHIFT: begin
                if (cs_rise_q) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (sclk_rise_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                        rd_vld_d = 1'b1;
                        state_d  = S_RD_END;
                    end
                end else if (sclk_fall_q) begin
                    rd_sh_d = {rd_sh_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            S_RD_END: begin
                if (cs_rise_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // SPI commit wins over a same-cycle host write
        if (spi_we) begin
            bank_d[wr_addr_d] = wr_data_d;
        end else if (host_we) begin
            bank_d[host_addr] = host_wdata;
        end
    end

    // State register; synchronous reset clears everything including the bank
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            mosi_smp_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rd_addr_q   <= '0;
            rd_sh_q     <= '0;
            bank_q      <= '{default: '0};
            wr_vld_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef SPI_SLV_RD_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            mosi_smp_q  <= mosi_smp_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rd_addr_q   <= rd_addr_d;
            rd_sh_q     <= rd_sh_d;
            bank_q      <= bank_d;
            wr_vld_q    <= wr_vld_d;
            rd_vld_q    <= rd_vld_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef SPI_SLV_RD_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign miso_oe   = (state_q == S_RD_SHIFT) || (state_q == S_RD_END);
    assign miso      = miso_oe & rd_sh_q[DATA_WIDTH-1];
    assign wr_vld    = wr_vld_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_vld    = rd_vld_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed testbench for spi_slave_regbank (8x8 bank, 2 sync stages).
// Covers the SPI_SLV_RD_TIMEOUT_EN build or the default build, whichever is compiled.
module tb_spi_slave_regbank;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int H  = 6;   // sclk half period in clk cycles

    logic          clk = 1'b0;
    logic          rst, sclk, cs, mosi, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          miso, miso_oe, wr_vld, rd_vld, frame_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    always #5 clk = ~clk;

    spi_slave_regbank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2), .RD_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr_vld(wr_vld), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_vld(rd_vld), .frame_err(frame_err),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata)
    );

    // Pulse monitors: count high cycles of each strobe
    always @(posedge clk) begin
        if (wr_vld) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= wr_addr;
            last_wr_data <= wr_data;
        end
        if (rd_vld) rd_cnt <= rd_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_pulse(input logic b);
        mosi = b;
        wait_clk(H);
        sclk = 1'b1;
        wait_clk(H);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [11:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sclk_pulse(v[i]);
    endtask

    task automatic cs_open();
        cs = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_close();
        wait_clk(H);
        cs = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic read_cmd(input logic [AW-1:0] a);
        cs_open();
        send_bits({8'b0, 1'b0, a}, 4);
        cs_close();
    endtask

    // Opens the data window and clocks n bits; caller closes cs
    task automatic read_data(input int n, output logic [DW-1:0] d, output logic oe_ok);
        d = '0;
        oe_ok = 1'b1;
        mosi = 1'b0;
        cs = 1'b0;
        wait_clk(H);
        for (int i = 0; i < n; i++) begin
            if (!miso_oe) oe_ok = 1'b0;
            d = {d[DW-2:0], miso};
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
            wait_clk(H);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        wait_clk(5);
        checks++;
        if ({miso, miso_oe} !== 2'b00) begin
            failures++;
            $display("FAIL reset_miso: got miso=%b oe=%b expected 0 0", miso, miso_oe);
        end
        checks++;
        if ({wr_vld, rd_vld, frame_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses: got wr=%b rd=%b err=%b expected 000", wr_vld, rd_vld, frame_err);
        end
        checks++;
        if ({wr_addr, wr_data} !== 11'd0) begin
            failures++;
            $display("FAIL reset_wr_bus: got addr=%0d data=%h expected 0 00", wr_addr, wr_data);
        end
        rst = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_write();
        int w0, e0, r0;
        logic [DW-1:0] d;
        logic ok;
        w0 = wr_cnt; e0 = err_cnt;
        cs_open();
        send_bits(12'hBA5, 12);
        cs_close();
        checks++;
        if (wr_cnt - w0 != 1) begin
            failures++;
            $display("FAIL write_vld_count: got %0d expected 1", wr_cnt - w0);
        end
        checks++;
        if (last_wr_addr !== 3'd3 || last_wr_data !== 8'hA5) begin
            failures++;
            $display("FAIL write_bus: got addr=%0d data=%h expected 3 a5", last_wr_addr, last_wr_data);
        end
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL write_no_err: got %0d errors expected 0", err_cnt - e0);
        end
        read_cmd(3'd3);
        wait_clk(20);
        r0 = rd_cnt;
        read_data(8, d, ok);
        cs_close();
        checks++;
        if (d !== 8'hA5 || !ok) begin
            failures++;
            $display("FAIL write_readback: got %h oe_ok=%b expected a5 1", d, ok);
        end
        checks++;
        if (rd_cnt - r0 != 1) begin
            failures++;
            $display("FAIL write_readback_rdvld: got %0d expected 1", rd_cnt - r0);
        end
    endtask

    task automatic test_host_read();
        int r0;
        logic [DW-1:0] d;
        logic ok;
        host_addr = 3'd5; host_wdata = 8'h3C; host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
        read_cmd(3'd5);
        wait_clk(100);
        r0 = rd_cnt;
        read_data(8, d, ok);
        checks++;
        if (!miso_oe) begin
            failures++;
            $display("FAIL host_read_oe_end: got oe=0 expected 1 before cs rise");
        end
        cs_close();
        checks++;
        if (d !== 8'h3C || !ok) begin
            failures++;
            $display("FAIL host_read_data: got %h oe_ok=%b expected 3c 1", d, ok);
        end
        checks++;
        if (rd_cnt - r0 != 1) begin
            failures++;
            $display("FAIL host_read_rdvld: got %0d expected 1", rd_cnt - r0);
        end
        checks++;
        if ({miso_oe, miso} !== 2'b00) begin
            failures++;
            $display("FAIL host_read_release: got oe=%b miso=%b expected 0 0", miso_oe, miso);
        end
    endtask

    task automatic test_abort_write();
        int w0, e0;
        logic [DW-1:0] d;
        logic ok;
        w0 = wr_cnt; e0 = err_cnt;
        cs_open();
        send_bits(12'h05F, 7);
        cs_close();
        checks++;
        if (err_cnt - e0 != 1 || wr_cnt != w0) begin
            failures++;
            $display("FAIL abort_write: got err=%0d wr=%0d expected 1 0", err_cnt - e0, wr_cnt - w0);
        end
        read_cmd(3'd3);
        read_data(8, d, ok);
        cs_close();
        checks++;
        if (d !== 8'hA5) begin
            failures++;
            $display("FAIL abort_write_bank: got %h expected a5", d);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d;
        logic ok;
        cs_open();
        send_bits(12'h508, 11);
        mosi = 1'b1;
        wait_clk(H);
        host_addr = 3'd2; host_wdata = 8'h22;
        sclk = 1'b1;
        wait_clk(3);
        host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
        checks++;
        if (wr_vld !== 1'b1) begin
            failures++;
            $display("FAIL collision_wr_latency: got wr_vld=%b expected 1 at pin edge + 4 clk", wr_vld);
        end
        wait_clk(H - 4);
        sclk = 1'b0;
        cs_close();
        read_cmd(3'd2);
        read_data(8, d, ok);
        cs_close();
        checks++;
        if (d !== 8'h11) begin
            failures++;
            $display("FAIL collision_bank: got %h expected 11", d);
        end
    endtask

    task automatic test_rd_extra_clk();
        int e0;
        e0 = err_cnt;
        cs_open();
        send_bits(12'h003, 5);
        cs_close();
        checks++;
        if (err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL rd_cmd_extra_clk: got err=%0d expected 1", err_cnt - e0);
        end
    endtask

    task automatic test_rd_abort();
        int e0, r0;
        logic [DW-1:0] d;
        logic ok;
        read_cmd(3'd3);
        e0 = err_cnt; r0 = rd_cnt;
        read_data(3, d, ok);
        cs_close();
        checks++;
        if (err_cnt - e0 != 1 || rd_cnt != r0) begin
            failures++;
            $display("FAIL rd_abort_pulses: got err=%0d rd=%0d expected 1 0", err_cnt - e0, rd_cnt - r0);
        end
        checks++;
        if (d !== 8'h05 || miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL rd_abort_bits: got bits=%h oe=%b expected 05 0", d, miso_oe);
        end
    endtask

    task automatic test_rd_wait();
        int e0, w0;
        logic [DW-1:0] d;
        logic ok;
        e0 = err_cnt;
`ifdef SPI_SLV_RD_TIMEOUT_EN
        read_cmd(3'd3);
        wait_clk(238);
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL timeout_early: got err=%0d expected 0 before cycle 255", err_cnt - e0);
        end
        wait_clk(62);
        checks++;
        if (err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL timeout_fire: got err=%0d expected 1", err_cnt - e0);
        end
        w0 = wr_cnt;
        cs_open();
        send_bits(12'hC55, 12);
        cs_close();
        checks++;
        if (wr_cnt - w0 != 1 || last_wr_addr !== 3'd4 || last_wr_data !== 8'h55) begin
            failures++;
            $display("FAIL timeout_next_write: got wr=%0d addr=%0d data=%h expected 1 4 55",
                     wr_cnt - w0, last_wr_addr, last_wr_data);
        end
`else
        w0 = wr_cnt;
        read_cmd(3'd3);
        wait_clk(300);
        read_data(8, d, ok);
        cs_close();
        checks++;
        if (d !== 8'hA5 || err_cnt != e0 || wr_cnt != w0) begin
            failures++;
            $display("FAIL long_wait_read: got %h err=%0d expected a5 0", d, err_cnt - e0);
        end
`endif
    endtask

    task automatic test_rst_midframe();
        int e0, r0;
        logic [DW-1:0] d;
        logic ok;
        logic [AW-1:0] addrs [3];
        addrs = '{3'd2, 3'd3, 3'd5};
        read_cmd(3'd3);
        e0 = err_cnt; r0 = rd_cnt;
        read_data(4, d, ok);
        rst = 1'b1;
        wait_clk(1);
        checks++;
        if ({miso, miso_oe} !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_outputs: got miso=%b oe=%b expected 0 0", miso, miso_oe);
        end
        cs = 1'b1; sclk = 1'b0;
        wait_clk(10);
        rst = 1'b0;
        wait_clk(5);
        checks++;
        if (rd_cnt != r0 || err_cnt != e0) begin
            failures++;
            $display("FAIL rst_mid_pulses: got rd=%0d err=%0d expected 0 0", rd_cnt - r0, err_cnt - e0);
        end
        for (int i = 0; i < 3; i++) begin
            read_cmd(addrs[i]);
            read_data(8, d, ok);
            cs_close();
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL rst_bank_clear: addr %0d got %h expected 00", addrs[i], d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_host_read();
        test_abort_write();
        test_collision();
        test_rd_extra_clk();
        test_rd_abort();
        test_rd_wait();
        test_rst_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
